// File: rtl/multi_clock_divider_pkg.sv
// Shared constants for the multi-channel clock divider.
// Optional feature macro: MULTI_CLOCK_DIVIDER_CASCADE_EN (see multi_clock_divider.sv).
package multi_clock_divider_pkg;

    localparam int unsigned DEFAULT_NUM_CH = 3;
    localparam int unsigned DEFAULT_WIDTH  = 28;
    localparam int unsigned MAX_NUM_CH     = 16;

    // Board clock and common half-period presets (in board clock cycles)
    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned HP_10HZ  = 2_500_000;
    localparam int unsigned HP_1HZ   = 25_000_000;
    localparam int unsigned HP_0P1HZ = 250_000_000;

    // Half-period needed for a given output frequency from the board clock.
    // Returns 0 (channel idle) for a zero request.
    function automatic int unsigned hp_for_hz(input int unsigned hz);
        if (hz == 0) begin
            return 0;
        end
        return CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: half-period counter, output toggle, tick and the
// pending half-period register that is applied at the next terminal count.
module clock_divider_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv_req,
    input  logic [WIDTH-1:0] half_period,
    input  logic             load,
    input  logic             sync_restart,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_hp;
    logic [WIDTH-1:0] pend_hp;
    logic             pend_v;
    logic             out_q;
    logic             tick_q;

    logic             running;
    logic             adv;
    logic             terminal;
    logic             take_pending;

    // Advance / terminal-count decode; an idle channel takes a pending value at once
    always_comb begin
        running      = (active_hp != '0);
        adv          = adv_req && running;
        terminal     = adv && (cnt == (active_hp - WIDTH'(1)));
        take_pending = pend_v && (terminal || !running);
    end

    // Counter, output toggle and tick; restart forces phase zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (sync_restart) begin
            cnt    <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (terminal) begin
            cnt    <= '0;
            out_q  <= ~out_q;
            tick_q <= 1'b1;
        end else if (adv) begin
            cnt    <= cnt + WIDTH'(1);
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
        end
    end

    // Active and pending half-period registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_hp <= '0;
            pend_hp   <= '0;
            pend_v    <= 1'b0;
        end else if (sync_restart) begin
            // A load presented together with restart bypasses the pending stage
            if (load) begin
                active_hp <= half_period;
                pend_hp   <= half_period;
            end else if (pend_v) begin
                active_hp <= pend_hp;
            end
            pend_v <= 1'b0;
        end else begin
            // Transfer uses the value held before this cycle's load, so a load
            // coinciding with a terminal count stays pending for the next one
            if (take_pending) begin
                active_hp <= pend_hp;
            end
            if (load) begin
                pend_hp <= half_period;
                pend_v  <= 1'b1;
            end else if (take_pending) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;
    assign pending = pend_v;

endmodule

// File: rtl/multi_clock_divider.sv
// Run-time programmable multi-channel clock divider.
// Optional feature macro: MULTI_CLOCK_DIVIDER_CASCADE_EN -- when defined,
// channel i>0 advances only on ticks of channel i-1 (cascaded chain).
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned WIDTH  = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*WIDTH-1:0] half_period,
    input  logic                    load,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    logic [NUM_CH-1:0] adv_req;

`ifdef MULTI_CLOCK_DIVIDER_CASCADE_EN
    // Cascaded chain: each later stage counts the registered ticks of the stage before it
    always_comb begin
        adv_req    = '0;
        adv_req[0] = en[0];
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            adv_req[i] = en[i] && tick[i-1];
        end
    end
`else
    // Independent channels: each advances on its own enable every clock
    always_comb begin
        adv_req = en;
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .adv_req      (adv_req[i]),
            .half_period  (half_period[i*WIDTH +: WIDTH]),
            .load         (load),
            .sync_restart (sync_restart),
            .clk_out      (clk_out[i]),
            .tick         (tick[i]),
            .pending      (pending[i])
        );
    end

endmodule
